usb_iso_audio_sink: RTL and testbench

//  Consumer of the isochronous OUT audio endpoint: takes the byte stream from USB_Transceiver
//  on endpoint EP, unpacks 16-bit little-endian stereo frames (L lo, L hi, R lo, R hi) and

---
 rtl/usb_iso_audio_sink.sv | 157 +++++++++++++++
 tb/tb_usb_iso_audio_sink.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/usb_iso_audio_sink.sv
// rtl/usb_iso_audio_sink.sv - isochronous OUT audio endpoint sink with packet-committed stereo FIFO
// Unpacks little-endian {L,R} 16-bit frames; only whole, error-free packets become visible to the reader.
module usb_iso_audio_sink #(
    parameter int EP         = 1,
    parameter int DEPTH_LOG2 = 8,
    parameter int MAX_PACKET = 192
) (
    input  logic                  Clk,
    input  logic                  Reset,
    input  logic [3:0]            Endpoint,
    input  logic                  OUT_SoP,
    input  logic                  OUT_EoP,
    input  logic [7:0]            OUT_Data,
    input  logic                  OUT_Valid,
    input  logic                  Error,
    input  logic                  AlternateSetting,
    input  logic                  Mute,
    input  logic                  Sample_Ready,
    output logic                  Sample_Valid,
    output logic [15:0]           Left,
    output logic [15:0]           Right,
    output logic [DEPTH_LOG2:0]   Level,
    output logic                  Overflow,
    output logic                  Underflow
);
    localparam int CW = $clog2(MAX_PACKET + 2);
    localparam logic [DEPTH_LOG2:0] FULL_CNT = {1'b1, {DEPTH_LOG2{1'b0}}};

    typedef enum logic [1:0] {IDLE, RECEIVE, DISCARD} rx_state_t;
    rx_state_t state, state_n;

    logic [31:0]         mem [0:(2**DEPTH_LOG2)-1];
    logic [DEPTH_LOG2:0] wr_ptr, wr_tmp, rd_ptr;
    logic [1:0]          byte_idx;
    logic [CW-1:0]       byte_cnt, cnt_next;
    logic [7:0]          b0, b1, b2;
    logic [15:0]         left_q, right_q;

    logic sop_any, sop_hit, data_beat, eop_beat, too_long, full;
    logic start, store, do_write, ovf, commit, rollback;

    always_comb begin
        sop_any   = OUT_Valid & OUT_SoP;
        sop_hit   = sop_any & (Endpoint == 4'(EP)) & AlternateSetting;
        data_beat = OUT_Valid & ~OUT_EoP & ~OUT_SoP;
        eop_beat  = OUT_Valid & OUT_EoP & ~OUT_SoP;
        cnt_next  = byte_cnt + 1'b1;
        too_long  = cnt_next > CW'(MAX_PACKET);
        full      = (wr_tmp - rd_ptr) == FULL_CNT;
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) state <= IDLE;
        else       state <= state_n;
    end

    always_comb begin
        state_n = state;
        if (!AlternateSetting) begin
            state_n = IDLE;
        end else begin
            case (state)
                IDLE:    if (sop_hit) state_n = RECEIVE;
                RECEIVE: begin
                    if (Error)                state_n = IDLE;
                    else if (sop_any)         state_n = sop_hit ? RECEIVE : IDLE;
                    else if (eop_beat)        state_n = IDLE;
                    else if (data_beat && (too_long || (byte_idx == 2'd3 && full)))
                                              state_n = DISCARD;
                end
                DISCARD: begin
                    if (Error || eop_beat)    state_n = IDLE;
                    else if (sop_any)         state_n = sop_hit ? RECEIVE : IDLE;
                end
                default:                      state_n = IDLE;
            endcase
        end
    end

    // A restart SoP wins over a stale packet, but an Error on the current packet wins over both.
    always_comb begin
        start    = sop_hit & ~(state != IDLE & Error);
        store    = AlternateSetting & (state == RECEIVE) & ~Error & data_beat & ~too_long;
        do_write = store & (byte_idx == 2'd3) & ~full;
        ovf      = store & (byte_idx == 2'd3) & full;
        commit   = AlternateSetting & (state == RECEIVE) & ~Error & eop_beat;
        rollback = (state != IDLE) & (Error | sop_any | (state == DISCARD));
    end

    always_ff @(posedge Clk) begin
        if (do_write) mem[wr_tmp[DEPTH_LOG2-1:0]] <= {OUT_Data, b2, b1, b0};
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            wr_ptr       <= '0;
            wr_tmp       <= '0;
            rd_ptr       <= '0;
            byte_idx     <= '0;
            byte_cnt     <= '0;
            b0           <= '0;
            b1           <= '0;
            b2           <= '0;
            left_q       <= '0;
            right_q      <= '0;
            Sample_Valid <= 1'b0;
            Overflow     <= 1'b0;
            Underflow    <= 1'b0;
        end else begin
            Overflow  <= ovf;
            Underflow <= Sample_Ready & ~Sample_Valid;
            if (!AlternateSetting) begin
                wr_ptr       <= '0;
                wr_tmp       <= '0;
                rd_ptr       <= '0;
                byte_idx     <= '0;
                byte_cnt     <= '0;
                Sample_Valid <= 1'b0;
            end else begin
                if (start) begin
                    wr_tmp   <= wr_ptr;
                    b0       <= OUT_Data;
                    byte_idx <= 2'd1;
                    byte_cnt <= CW'(1);
                end else if (rollback) begin
                    wr_tmp <= wr_ptr;
                end
                if (store) begin
                    byte_cnt <= cnt_next;
                    byte_idx <= byte_idx + 2'd1;
                    case (byte_idx)
                        2'd0:    b0 <= OUT_Data;
                        2'd1:    b1 <= OUT_Data;
                        2'd2:    b2 <= OUT_Data;
                        default: ;
                    endcase
                end
                if (do_write) wr_tmp <= wr_tmp + 1'b1;
                if (commit)   wr_ptr <= wr_tmp;
                // Head register refills one cycle after it empties, giving the 2-cycle pop-to-next gap.
                if (Sample_Valid && Sample_Ready) begin
                    rd_ptr       <= rd_ptr + 1'b1;
                    Sample_Valid <= 1'b0;
                end else if (!Sample_Valid && (wr_ptr != rd_ptr)) begin
                    left_q       <= mem[rd_ptr[DEPTH_LOG2-1:0]][15:0];
                    right_q      <= mem[rd_ptr[DEPTH_LOG2-1:0]][31:16];
                    Sample_Valid <= 1'b1;
                end
            end
        end
    end

    assign Level = wr_ptr - rd_ptr;
    assign Left  = Mute ? 16'h0000 : left_q;
    assign Right = Mute ? 16'h0000 : right_q;

endmodule

// File: tb/tb_usb_iso_audio_sink.sv
// tb/tb_usb_iso_audio_sink.sv - directed table-driven bench for usb_iso_audio_sink
module tb_usb_iso_audio_sink;
    logic        Clk = 1'b0;
    logic        Reset;
    logic [3:0]  Endpoint;
    logic        OUT_SoP, OUT_EoP, OUT_Valid, Error;
    logic [7:0]  OUT_Data;
    logic        AlternateSetting, Mute, Sample_Ready;
    logic        Sample_Valid, Overflow, Underflow;
    logic [15:0] Left, Right;
    logic [8:0]  Level;
    logic        sv4, ovf4, unf4;
    logic [15:0] left4, right4;
    logic [4:0]  level4;

    int checks = 0;
    int failures = 0;
    int ovf_cnt = 0;
    int ovf4_cnt = 0;

    always #5 Clk = ~Clk;

    usb_iso_audio_sink dut (
        .Clk(Clk), .Reset(Reset), .Endpoint(Endpoint), .OUT_SoP(OUT_SoP), .OUT_EoP(OUT_EoP),
        .OUT_Data(OUT_Data), .OUT_Valid(OUT_Valid), .Error(Error),
        .AlternateSetting(AlternateSetting), .Mute(Mute), .Sample_Ready(Sample_Ready),
        .Sample_Valid(Sample_Valid), .Left(Left), .Right(Right), .Level(Level),
        .Overflow(Overflow), .Underflow(Underflow)
    );

    usb_iso_audio_sink #(.DEPTH_LOG2(4)) dut4 (
        .Clk(Clk), .Reset(Reset), .Endpoint(Endpoint), .OUT_SoP(OUT_SoP), .OUT_EoP(OUT_EoP),
        .OUT_Data(OUT_Data), .OUT_Valid(OUT_Valid), .Error(Error),
        .AlternateSetting(AlternateSetting), .Mute(Mute), .Sample_Ready(Sample_Ready),
        .Sample_Valid(sv4), .Left(left4), .Right(right4), .Level(level4),
        .Overflow(ovf4), .Underflow(unf4)
    );

    always @(negedge Clk) begin
        if (Overflow) ovf_cnt++;
        if (ovf4)     ovf4_cnt++;
    end

    typedef struct {
        logic [15:0] l;
        logic [15:0] r;
        logic        mute;
        logic [15:0] exp_l;
        logic [15:0] exp_r;
    } vec_t;
    vec_t vecs[5];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic beat(input logic [7:0] d, input logic sop, input logic eop, input logic err);
        OUT_Data = d; OUT_SoP = sop; OUT_EoP = eop; Error = err; OUT_Valid = 1'b1;
        @(posedge Clk); #1;
        OUT_Valid = 1'b0; OUT_SoP = 1'b0; OUT_EoP = 1'b0; Error = 1'b0;
    endtask

    function automatic logic [15:0] exp_left(input logic [15:0] base, input int k);
        return base + 16'(k);
    endfunction

    function automatic logic [15:0] exp_right(input logic [15:0] base, input int k);
        return (base + 16'(k)) ^ 16'hA5A5;
    endfunction

    function automatic logic [7:0] byte_of(input logic [15:0] base, input int i);
        logic [15:0] l, r;
        l = exp_left(base, i / 4);
        r = exp_right(base, i / 4);
        case (i % 4)
            0:       return l[7:0];
            1:       return l[15:8];
            2:       return r[7:0];
            default: return r[15:8];
        endcase
    endfunction

    task automatic send_pkt(input logic [3:0] ep, input int nbytes, input logic [15:0] base, input int err_at);
        Endpoint = ep;
        for (int i = 0; i < nbytes; i++) beat(byte_of(base, i), i == 0, 1'b0, i == err_at);
        beat(8'h00, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic send_frame(input logic [15:0] l, input logic [15:0] r);
        Endpoint = 4'd1;
        beat(l[7:0], 1'b1, 1'b0, 1'b0);
        beat(l[15:8], 1'b0, 1'b0, 1'b0);
        beat(r[7:0], 1'b0, 1'b0, 1'b0);
        beat(r[15:8], 1'b0, 1'b0, 1'b0);
        beat(8'h00, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic wait_valid(input string name);
        for (int i = 0; i < 3 && !Sample_Valid; i++) begin
            @(posedge Clk); #1;
        end
        chk(name, 32'(Sample_Valid), 32'd1);
    endtask

    task automatic pop();
        Sample_Ready = 1'b1;
        @(posedge Clk); #1;
        Sample_Ready = 1'b0;
    endtask

    task automatic flush();
        AlternateSetting = 1'b0;
        repeat (2) begin @(posedge Clk); #1; end
        AlternateSetting = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        int snap, snap4;
        vecs[0] = '{l: 16'h1234, r: 16'h5678, mute: 1'b0, exp_l: 16'h1234, exp_r: 16'h5678};
        vecs[1] = '{l: 16'h7FFF, r: 16'h8001, mute: 1'b1, exp_l: 16'h0000, exp_r: 16'h0000};
        vecs[2] = '{l: 16'h8000, r: 16'hFFFF, mute: 1'b0, exp_l: 16'h8000, exp_r: 16'hFFFF};
        vecs[3] = '{l: 16'h0001, r: 16'h0000, mute: 1'b0, exp_l: 16'h0001, exp_r: 16'h0000};
        vecs[4] = '{l: 16'hBEEF, r: 16'hCAFE, mute: 1'b1, exp_l: 16'h0000, exp_r: 16'h0000};

        Reset = 1'b1; Endpoint = 4'd1; OUT_SoP = 1'b0; OUT_EoP = 1'b0; OUT_Data = 8'h00;
        OUT_Valid = 1'b0; Error = 1'b0; AlternateSetting = 1'b1; Mute = 1'b0; Sample_Ready = 1'b0;
        repeat (3) @(posedge Clk);
        #1;
        chk("reset_valid", 32'(Sample_Valid), 0);
        chk("reset_left", 32'(Left), 0);
        chk("reset_right", 32'(Right), 0);
        chk("reset_level", 32'(Level), 0);
        chk("reset_ovf_unf", {30'd0, Overflow, Underflow}, 0);
        Reset = 1'b0;
        @(posedge Clk); #1;

        for (int v = 0; v < 5; v++) begin
            Mute = vecs[v].mute;
            send_frame(vecs[v].l, vecs[v].r);
            chk("vec_level_commit", 32'(Level), 1);
            wait_valid("vec_valid");
            chk("vec_left", 32'(Left), 32'(vecs[v].exp_l));
            chk("vec_right", 32'(Right), 32'(vecs[v].exp_r));
            pop();
            chk("vec_level_pop", 32'(Level), 0);
            chk("vec_valid_drop", 32'(Sample_Valid), 0);
        end
        Mute = 1'b0;

        send_pkt(4'd1, 192, 16'h0100, 100);
        repeat (4) begin @(posedge Clk); #1; end
        chk("t2_err_level", 32'(Level), 0);
        chk("t2_err_valid", 32'(Sample_Valid), 0);
        send_pkt(4'd1, 192, 16'h0200, -1);
        chk("t2_good_level", 32'(Level), 48);
        for (int k = 0; k < 48; k++) begin
            wait_valid("t2_valid");
            chk("t2_left", 32'(Left), 32'(exp_left(16'h0200, k)));
            chk("t2_right", 32'(Right), 32'(exp_right(16'h0200, k)));
            pop();
        end
        chk("t2_drained", 32'(Level), 0);

        send_pkt(4'd1, 196, 16'h0300, -1);
        repeat (2) begin @(posedge Clk); #1; end
        chk("long_pkt_dropped", 32'(Level), 0);

        flush();
        snap = ovf_cnt; snap4 = ovf4_cnt;
        send_pkt(4'd1, 24, 16'h1000, -1);
        send_pkt(4'd1, 24, 16'h2000, -1);
        chk("t3_level_two_pkts", 32'(level4), 12);
        chk("t3_no_ovf_yet", 32'(ovf4_cnt - snap4), 0);
        send_pkt(4'd1, 24, 16'h3000, -1);
        chk("t3_level", 32'(level4), 12);
        chk("t3_ovf_pulses", 32'(ovf4_cnt - snap4), 1);
        chk("t3_big_fifo_level", 32'(Level), 18);
        chk("t3_big_fifo_no_ovf", 32'(ovf_cnt - snap), 0);

        flush();
        send_pkt(4'd1, 10, 16'h4000, -1);
        chk("t4_level", 32'(Level), 2);
        send_pkt(4'd2, 8, 16'h5000, -1);
        chk("t4_ep2_ignored", 32'(Level), 2);
        wait_valid("t4_valid");
        chk("t4_left0", 32'(Left), 32'(exp_left(16'h4000, 0)));
        pop();
        wait_valid("t4_valid1");
        chk("t4_right1", 32'(Right), 32'(exp_right(16'h4000, 1)));
        pop();
        chk("t4_level_empty", 32'(Level), 0);

        flush();
        pop();
        chk("t5_underflow", 32'(Underflow), 1);
        chk("t5_level", 32'(Level), 0);
        @(posedge Clk); #1;
        chk("t5_underflow_pulse", 32'(Underflow), 0);

        send_pkt(4'd1, 80, 16'h6000, -1);
        wait_valid("t6_valid");
        chk("t6_level20", 32'(Level), 20);
        AlternateSetting = 1'b0;
        @(posedge Clk); #1;
        chk("t6_flush_level", 32'(Level), 0);
        chk("t6_flush_valid", 32'(Sample_Valid), 0);
        AlternateSetting = 1'b1;
        @(posedge Clk); #1;

        Endpoint = 4'd1;
        for (int i = 0; i < 6; i++) beat(byte_of(16'h7000, i), i == 0, 1'b0, 1'b0);
        Reset = 1'b1;
        #1;
        chk("t6_reset_outputs", {Sample_Valid, Left, Level[6:0], Overflow, Underflow}, 0);
        chk("t6_reset_right", 32'(Right), 0);
        @(posedge Clk); #1;
        Reset = 1'b0;
        @(posedge Clk); #1;
        send_frame(16'hABCD, 16'h1357);
        chk("t6_after_reset_level", 32'(Level), 1);
        wait_valid("t6_after_reset_valid");
        chk("t6_after_reset_left", 32'(Left), 32'h0000ABCD);
        chk("t6_after_reset_right", 32'(Right), 32'h00001357);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
